// File: rtl/t_fsm_pkg.sv
// Shared types and constants for the toggle line decoder and its matching moore_t encoder.
// Build macro TOGGLE_DEC_PARITY_EN appends one even-parity bit to every frame.
package t_fsm_pkg;

    typedef enum logic {
        S_RECV = 1'b0,
        S_FULL = 1'b1
    } state_t;

    // Line level both ends agree on after reset.
    localparam logic Z_INIT_DEFAULT = 1'b0;

`ifdef TOGGLE_DEC_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int w);
        return w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/t_toggle_bitrec.sv
// Bit recovery for a toggle-encoded line: each sampled level is XORed with the previous
// sampled level to recover one data bit. Exposes the bit combinationally and registered.
module t_toggle_bitrec
    import t_fsm_pkg::*;
#(
    parameter logic Z_INIT = Z_INIT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_z_in,
    input  logic i_z_valid,
    output logic o_bit,
    output logic o_x_out,
    output logic o_x_valid
);

    logic r_z_prev;
    logic r_x_out;
    logic r_x_valid;
    logic w_bit;

    assign w_bit     = i_z_in ^ r_z_prev;
    assign o_bit     = w_bit;
    assign o_x_out   = r_x_out;
    assign o_x_valid = r_x_valid;

    // z_prev only advances on sampled cycles, so idle gaps of any length are harmless.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_z_prev  <= Z_INIT;
            r_x_out   <= 1'b0;
            r_x_valid <= 1'b0;
        end else begin
            r_x_valid <= i_z_valid;
            if (i_z_valid) begin
                r_z_prev <= i_z_in;
                r_x_out  <= w_bit;
            end
        end
    end

endmodule

// File: rtl/t_toggle_decoder.sv
// Toggle line decoder: recovers bits, assembles W-bit words LSB first and offers them on a
// valid/ready port with sticky overflow. Macro TOGGLE_DEC_PARITY_EN adds an even-parity check.
module t_toggle_decoder
    import t_fsm_pkg::*;
#(
    parameter int   W      = 8,
    parameter logic Z_INIT = Z_INIT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         z_in,
    input  logic         z_valid,
    output logic         x_out,
    output logic         x_valid,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         overflow,
    output logic         parity_err
);

    localparam int FRAME_LEN = frame_len(W);
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic             w_bit;
    logic             w_last;
    logic [W-1:0]     w_word;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [W-1:0]     r_shift;
    logic [W-1:0]     r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             w_load_perr;
    logic             r_parity_err;
    state_t           r_state;

    t_toggle_bitrec #(
        .Z_INIT(Z_INIT)
    ) u_bitrec (
        .clk      (clk),
        .reset    (reset),
        .i_z_in   (z_in),
        .i_z_valid(z_valid),
        .o_bit    (w_bit),
        .o_x_out  (x_out),
        .o_x_valid(x_valid)
    );

    assign w_last = z_valid && (r_bit_cnt == LAST_CNT);

    // Word as it stands with the current bit dropped into its slot; the parity bit
    // position matches no data slot, so it never lands in the word.
    for (genvar gi = 0; gi < W; gi++) begin : g_word
        assign w_word[gi] = (r_bit_cnt == CNT_W'(gi)) ? w_bit : r_shift[gi];
    end

`ifdef TOGGLE_DEC_PARITY_EN
    assign w_load_perr = (^r_shift) ^ w_bit;
`else
    assign w_load_perr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else if (z_valid) begin
            r_shift   <= w_word;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RECV;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                S_RECV: begin
                    if (w_last) begin
                        r_data_out   <= w_word;
                        r_parity_err <= w_load_perr;
                        r_data_valid <= 1'b1;
                        r_state      <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_last && data_ready) begin
                        // Consumer takes the old word as the next one lands: no bubble.
                        r_data_out   <= w_word;
                        r_parity_err <= w_load_perr;
                    end else if (w_last) begin
                        r_overflow <= 1'b1;
                    end else if (data_ready) begin
                        r_data_valid <= 1'b0;
                        r_parity_err <= 1'b0;
                        r_state      <= S_RECV;
                    end
                end
                default: begin
                    r_state      <= S_RECV;
                    r_data_valid <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign overflow   = r_overflow;
    assign parity_err = r_parity_err;

endmodule
